up_counter: RTL
===============

UP_COUNTER -- requirements
Module: up_counter

Interface
REQ-001 SHALL provide parameter: WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 SHALL provide port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, synchronous, active-high, sampled on rising clk edge.
REQ-004 SHALL provide port: en  input  1  count enable.
REQ-005 SHALL provide port: load  input  1  parallel-load strobe.
REQ-006 SHALL provide port: din  input  WIDTH  parallel-load value.
REQ-007 SHALL provide port: max  input  WIDTH  terminal value; counter modulus = max+1.
REQ-008 SHALL provide port: count  output  WIDTH  current count, driven directly from a register.
REQ-009 SHALL provide port: tc  output  1  terminal-count/carry for cascading, combinational.
REQ-010 SHALL provide port: wrap  output  1  registered one-cycle pulse indicating a wrap occurred on the previous edge.

Function
REQ-011 SHALL apply per-edge priority: rst > load > en > hold.
REQ-012 load=1: count <= din on the next edge, including din > max; wrap <= 0.
REQ-013 en=1, load=0, count < max: count <= count+1; wrap <= 0.
REQ-014 en=1, load=0, count >= max: count <= 0; wrap <= 1 for exactly one cycle.
REQ-015 en=0, load=0: count holds; wrap <= 0.
REQ-016 tc SHALL equal en AND (count >= max), with no register stage, so that a downstream stage enabled by tc advances on the same edge as the wrap.
REQ-017 The compare SHALL use the current max; a change in max mid-count takes effect on the next edge, with no restart.
REQ-018 max=0: count stays 0; tc=en; wrap pulses on every enabled edge.
REQ-019 max = all ones: full 2^WIDTH sequence; increment arithmetic SHALL be modulo 2^WIDTH, with no out-of-width carry.
REQ-020 load and en both high at count=max: load wins; count=din; wrap=0.
REQ-021 count and wrap SHALL be the only state; no other register SHALL alter their sequence.

Reset
REQ-022 rst=1 at an edge: count <= 0 and wrap <= 0, regardless of load, en, din or max.
REQ-023 Reset mid-count SHALL take effect on that edge; counting resumes from 0 on the first edge with rst=0 and en=1.
REQ-024 After reset, tc SHALL equal en AND (max==0); before the first reset edge, outputs are undefined.

Configuration
REQ-025 Macro UP_COUNTER_SATURATE_EN SHALL select saturation mode.
REQ-026 When UP_COUNTER_SATURATE_EN is defined: with en=1, load=0 and count >= max, count <= max, which holds at max or clamps an out-of-range loaded value; wrap SHALL stay 0 permanently; tc behaves per REQ-016.
REQ-027 When UP_COUNTER_SATURATE_EN is undefined: wrap behaviour per REQ-014 applies, with no saturation logic present.

Verification (WIDTH=4, macro undefined unless stated)
REQ-028 Drive rst=1, load=1, din=9, en=1 for one edge -> count=0, wrap=0.
REQ-029 Set max=15, en=1 from count=0 for 16 edges -> count steps 1..15 then 0; tc=1 only while count=15; wrap=1 for exactly the cycle where count=0.
REQ-030 Set max=5, en=1 -> sequence 0,1,2,3,4,5,0 with a wrap pulse after 5->0; then en=0 for 3 edges -> count holds; tc=0.
REQ-031 Set max=5 and load din=12 -> count=12; next edge with en=1 -> count=0, wrap=1; with load=1, en=1, din=3 at count=5 -> count=3, wrap=0.
REQ-032 Set max=0, en=1 for 4 edges -> count=0 throughout, tc=1, wrap=1 on each cycle after the first edge; assert rst mid-run -> wrap=0 next cycle.
REQ-033 Define UP_COUNTER_SATURATE_EN, set max=5, en=1 for 10 edges -> count reaches 5 and holds; wrap=0 always; tc=1 from count=5 onward.

Source files
------------

// File: rtl/up_counter.sv
// Modulo-(max+1) up counter with parallel load, cascade carry (tc) and a registered wrap pulse.
// Define UP_COUNTER_SATURATE_EN to make the counter clamp at max instead of wrapping.
module up_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic [WIDTH-1:0] max,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   logic             at_top;
   logic [WIDTH-1:0] count_nxt;
   logic             wrap_nxt;

   // ">=" rather than "==" so a loaded value above max, or a lowered max, still terminates.
   assign at_top = (count >= max);
   assign tc     = en & at_top;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      count_nxt = count;
      wrap_nxt  = 1'b0;
      if (load) begin
         count_nxt = din;
      end else if (en) begin
         if (at_top) begin
`ifdef UP_COUNTER_SATURATE_EN
            count_nxt = max;
`else
            count_nxt = '0;
            wrap_nxt  = 1'b1;
`endif
         end else begin
            count_nxt = count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         count <= count_nxt;
         wrap  <= wrap_nxt;
      end
   end

endmodule
